// File: rtl/fifo_pkg.sv
// Shared types for the fifo push arbiter: data width and lock FSM states.
package fifo_pkg;

  localparam int WIDTH = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: one-hot grant to the first asserted req at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a fifo with occupancy tracking and a sticky flag-mismatch detector.
// Define FIFO_ARB_LOCK_EN to add the lock port and the ARB/LOCKED burst-lock FSM.
module fifo_push_arbiter
  import fifo_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NREQ-1:0]             lock,
`endif
  output logic [NREQ-1:0]             gnt,
  output logic                        push,
  output logic [WIDTH-1:0]            data_in,
  input  logic                        pop_req,
  output logic                        pop,
  input  logic                        full,
  input  logic                        empty,
  output logic [CW-1:0]               count,
  output logic                        sync_err
);

  logic [PW-1:0]   rr_ptr, ptr_nxt, rr_idx;
  logic [NREQ-1:0] rr_gnt, gnt_c;
  logic            at_full;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign at_full = (count == CW'(DEPTH));

  rr_pick #(.N(NREQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int k = 0; k < NREQ; k++)
      if (rr_gnt[k]) rr_idx = PW'(k);
  end

`ifdef FIFO_ARB_LOCK_EN
  arb_state_t    state, state_nxt;
  logic [PW-1:0] lock_owner, owner_nxt;

  always_comb begin
    state_nxt = state;
    owner_nxt = lock_owner;
    ptr_nxt   = rr_ptr;
    gnt_c     = '0;
    case (state)
      ARB: begin
        if (!at_full && |rr_gnt) begin
          gnt_c   = rr_gnt;
          ptr_nxt = inc(rr_idx);
          if (lock[rr_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = rr_idx;
          end
        end
      end
      LOCKED: begin
        // Owner keeps the fifo while it requests; pointer is frozen until release.
        if (req[lock_owner] && !at_full) gnt_c[lock_owner] = 1'b1;
        if (!lock[lock_owner] || !req[lock_owner]) begin
          state_nxt = ARB;
          ptr_nxt   = inc(lock_owner);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ARB;
      lock_owner <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= owner_nxt;
    end
  end
`else
  always_comb begin
    gnt_c   = '0;
    ptr_nxt = rr_ptr;
    if (!at_full && |rr_gnt) begin
      gnt_c   = rr_gnt;
      ptr_nxt = inc(rr_idx);
    end
  end
`endif

  // Outputs stay quiet while reset is held so nothing reaches the fifo before state is known.
  assign gnt  = reset_n ? gnt_c : '0;
  assign push = |gnt;
  assign pop  = reset_n && pop_req && (count != '0);

  always_comb begin
    data_in = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt[k]) data_in = req_data[k];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      count    <= '0;
      sync_err <= 1'b0;
    end else begin
      rr_ptr <= ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (((count == '0) != empty) || (at_full != full)) sync_err <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning number of push requesters (2..8).
REQ-002 Parameter DEPTH, default 16, meaning capacity of the downstream fifo in words.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  NREQ  per-requester push request.
REQ-006 req_data  input  NREQ x WIDTH  per-requester push word.
REQ-007 lock  input  NREQ  per-requester burst-lock request; present only with FIFO_ARB_LOCK_EN.
REQ-008 gnt  output  NREQ  one-hot push grant, combinational.
REQ-009 push  output  1  push strobe to fifo.
REQ-010 data_in  output  WIDTH  word to fifo.
REQ-011 pop_req  input  1  consumer pop request.
REQ-012 pop  output  1  pop strobe to fifo.
REQ-013 full, empty  input  1 each  fifo status flags.
REQ-014 count  output  log2(DEPTH)+1  arbiter-tracked occupancy, registered.
REQ-015 sync_err  output  1  sticky flag for tracker/fifo mismatch, registered.

Function
REQ-016 gnt SHALL be all-zero when count == DEPTH, else SHALL be one-hot to the first asserted req searching upward from rr_ptr modulo NREQ.
REQ-017 push SHALL equal OR of gnt; data_in SHALL equal req_data of the granted index (all zeros when no grant); zero-cycle latency.
REQ-018 On each granted cycle rr_ptr SHALL update to (granted index + 1) mod NREQ; otherwise it SHALL hold.
REQ-019 pop SHALL equal pop_req AND (count != 0).
REQ-020 count SHALL update each clock: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-021 Simultaneous push and pop at count == DEPTH: no grant (REQ-016), so pop only; count decrements.
REQ-022 Simultaneous push and pop at count == 0: pop suppressed (REQ-019), push only; count increments.
REQ-023 sync_err SHALL set at a clock when (count == 0) != empty or (count == DEPTH) != full, and hold until reset.
REQ-024 Requesters whose req is low SHALL never receive gnt; gnt SHALL never be multi-hot.

Reset
REQ-025 While reset_n is low at a clock edge: count = 0, rr_ptr = 0, sync_err = 0, state = ARB.
REQ-026 Combinational outputs during reset SHALL follow the reset register values, so gnt, push and pop are 0 while count = 0, until the cycle after reset_n rises; reset mid-burst SHALL drop any lock.

Configuration
REQ-027 With FIFO_ARB_LOCK_EN defined, an FSM {ARB, LOCKED} and a lock_owner register SHALL be included.
REQ-028 ARB -> LOCKED when the granted requester has lock high; LOCKED grants only lock_owner while its req is high and count < DEPTH; rr_ptr holds while LOCKED.
REQ-029 LOCKED -> ARB at the first clock where lock_owner has lock low or req low; rr_ptr then becomes (lock_owner + 1) mod NREQ.
REQ-030 Without FIFO_ARB_LOCK_EN, the lock port, FSM and lock_owner SHALL be absent, and behaviour SHALL be pure round-robin.

Structure
REQ-031 WIDTH and the arb_state_t enum {ARB, LOCKED} SHALL reside in fifo_pkg; the module imports fifo_pkg.
REQ-032 The round-robin priority pick SHALL be a sub-module rr_pick (req vector and pointer in, one-hot out, combinational).

Verification
REQ-033 Reset 5 cycles, all req held high, DEPTH=16, no pops -> grants 0,1,2,3,0,... for 16 cycles, then gnt=0 with count=16.
REQ-034 count=16, req[2]=1 and pop_req=1 same cycle -> gnt=0, pop=1, count becomes 15; next cycle gnt[2]=1.
REQ-035 count=0, pop_req=1 alone -> pop=0, count stays 0; with req[1]=1 also -> push=1, pop=0, count becomes 1.
REQ-036 Force empty=0 while count=0 -> sync_err=1 next cycle and stays 1 until reset_n low.
REQ-037 With FIFO_ARB_LOCK_EN: req[1] and lock[1] high 4 cycles, req[0] and req[3] high -> gnt[1] on all 4; lock[1] drops -> next grant to 3, then 0.
REQ-038 Assert reset_n low mid-lock with count=7 -> at the next edge count=0, state=ARB, rr_ptr=0.
